// File: rtl/pio_seq_loader.sv
// Boot-time program/config loader and run-time TX feeder for one pio block.
// ROM images are packed parameters; entry i sits at bits [i*W +: W] (W=16 prog, 36 conf).
module pio_seq_loader #(
    parameter int NUM_SM   = 2,
    parameter int PROG_LEN = 32,
    parameter int CONF_LEN = 10,
    parameter logic [PROG_LEN*16-1:0]        PROG_IMAGE = '0,
    parameter logic [NUM_SM*CONF_LEN*36-1:0] CONF_IMAGE = '0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              restart_i,
    input  logic              push_valid_i,
    input  logic [31:0]       push_data_i,
    input  logic [NUM_SM-1:0] push_mask_i,
    output logic              push_ready_o,
    output logic              cfg_done_o,
    output logic [3:0]        action_o,
    output logic [31:0]       din_o,
    output logic [4:0]        index_o,
    output logic [1:0]        mindex_o,
    input  logic [3:0]        tx_full_i
);

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_CONF,
        ST_GAP,
        ST_RUN,
        ST_PUSH
    } state_t;

    typedef logic [NUM_SM-1:0] mask_t;

    localparam logic [4:0] P_LAST  = 5'(PROG_LEN - 1);
    localparam logic [4:0] C_LAST  = 5'(CONF_LEN - 1);
    localparam logic [1:0] SM_LAST = 2'(NUM_SM - 1);

    localparam logic [3:0] ACT_NONE = 4'd0;
    localparam logic [3:0] ACT_LOAD = 4'd1;
    localparam logic [3:0] ACT_PUSH = 4'd4;

    // NOTE: the ROMs are pure wiring from the image parameters, so there is no storage to reset.
    logic [15:0] prog_rom [32];
    logic [35:0] conf_rom [128];

    for (genvar i = 0; i < 32; i++) begin : g_prog
        if (i < PROG_LEN) begin : g_used
            assign prog_rom[i] = PROG_IMAGE[i*16 +: 16];
        end else begin : g_pad
            assign prog_rom[i] = '0;
        end
    end

    for (genvar i = 0; i < 128; i++) begin : g_conf
        if (i < NUM_SM * CONF_LEN) begin : g_used
            assign conf_rom[i] = CONF_IMAGE[i*36 +: 36];
        end else begin : g_pad
            assign conf_rom[i] = '0;
        end
    end

    state_t      state_q, state_d;
    logic [4:0]  p_q, p_d;
    logic [4:0]  c_q, c_d;
    logic [1:0]  sm_q, sm_d;
    logic [6:0]  ptr_q, ptr_d;
    mask_t       mask_q, mask_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  action_q, action_d;
    logic [31:0] din_q, din_d;
    logic [4:0]  index_q, index_d;
    logic [1:0]  mindex_q, mindex_d;
    logic        push_ready_q, push_ready_d;
    logic        cfg_done_q, cfg_done_d;

    logic [35:0] conf_word;
    mask_t       low_oh;
    logic [3:0]  low_oh4;
    logic [1:0]  sel_m;
    logic        sel_full;

    assign conf_word = conf_rom[ptr_q];

    // Lowest pending machine: isolate the least significant set bit of the mask.
    assign low_oh   = mask_q & (~mask_q + mask_t'(1));
    assign low_oh4  = 4'(low_oh);
    assign sel_full = |(low_oh4 & tx_full_i);

    always_comb begin
        sel_m = '0;
        for (int i = 0; i < NUM_SM; i++) begin
            if (low_oh[i]) begin
                sel_m = 2'(i);
            end
        end
    end

    // NOTE: every next-state signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        p_d          = p_q;
        c_d          = c_q;
        sm_d         = sm_q;
        ptr_d        = ptr_q;
        mask_d       = mask_q;
        data_d       = data_q;
        action_d     = ACT_NONE;
        din_d        = din_q;
        index_d      = index_q;
        mindex_d     = mindex_q;
        push_ready_d = push_ready_q;
        cfg_done_d   = cfg_done_q;

        if (restart_i) begin
            state_d      = ST_LOAD;
            p_d          = '0;
            mask_d       = '0;
            push_ready_d = 1'b0;
            cfg_done_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_LOAD: begin
                    action_d = ACT_LOAD;
                    index_d  = p_q;
                    din_d    = {16'b0, prog_rom[p_q]};
                    if (p_q == P_LAST) begin
                        state_d = ST_CONF;
                        sm_d    = '0;
                        c_d     = '0;
                        ptr_d   = '0;
                    end else begin
                        p_d = p_q + 5'd1;
                    end
                end

                ST_CONF: begin
                    action_d = conf_word[35:32];
                    din_d    = conf_word[31:0];
                    mindex_d = sm_q;
                    ptr_d    = ptr_q + 7'd1;
                    if (c_q == C_LAST) begin
                        state_d = ST_GAP;
                    end else begin
                        c_d = c_q + 5'd1;
                    end
                end

                ST_GAP: begin
                    if (sm_q == SM_LAST) begin
                        state_d      = ST_RUN;
                        cfg_done_d   = 1'b1;
                        push_ready_d = 1'b1;
                    end else begin
                        state_d = ST_CONF;
                        sm_d    = sm_q + 2'd1;
                        c_d     = '0;
                    end
                end

                ST_RUN: begin
                    if (push_valid_i && push_ready_q) begin
                        data_d       = push_data_i;
                        mask_d       = push_mask_i;
                        push_ready_d = 1'b0;
                        state_d      = ST_PUSH;
                    end
                end

                ST_PUSH: begin
                    if (mask_q == '0) begin
                        state_d      = ST_RUN;
                        push_ready_d = 1'b1;
                    end else if (!sel_full) begin
                        action_d = ACT_PUSH;
                        mindex_d = sel_m;
                        din_d    = data_q;
                        mask_d   = mask_q & ~low_oh;
                    end
                end

                default: begin
                    state_d = ST_LOAD;
                    p_d     = '0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_LOAD;
            p_q          <= '0;
            c_q          <= '0;
            sm_q         <= '0;
            ptr_q        <= '0;
            mask_q       <= '0;
            data_q       <= '0;
            action_q     <= ACT_NONE;
            din_q        <= '0;
            index_q      <= '0;
            mindex_q     <= '0;
            push_ready_q <= 1'b0;
            cfg_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            c_q          <= c_d;
            sm_q         <= sm_d;
            ptr_q        <= ptr_d;
            mask_q       <= mask_d;
            data_q       <= data_d;
            action_q     <= action_d;
            din_q        <= din_d;
            index_q      <= index_d;
            mindex_q     <= mindex_d;
            push_ready_q <= push_ready_d;
            cfg_done_q   <= cfg_done_d;
        end
    end

    assign push_ready_o = push_ready_q;
    assign cfg_done_o   = cfg_done_q;
    assign action_o     = action_q;
    assign din_o        = din_q;
    assign index_o      = index_q;
    assign mindex_o     = mindex_q;

endmodule
